// File: rtl/control_adunare_fp.sv
// FP adder sequencer: load, exponent compare, align, add, normalise; done at cycle 5+d+n after start.
// One request in flight; start is only honoured in IDLE (ready=1) and ignored until done has pulsed.
module control_adunare_fp #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 25
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  output logic             ready,
  input  logic [EXP_W-1:0] exp_diff,
  input  logic             swap,
  input  logic             carry_out,
  input  logic             sum_msb,
  input  logic             sum_zero,
  output logic             load_ops,
  output logic             load_mants,
  output logic             swap_sel,
  output logic             shift_align,
  output logic             load_sum,
  output logic             shift_norm_r,
  output logic             shift_norm_l,
  output logic             exp_inc,
  output logic             exp_dec,
  output logic             exp_zero,
  output logic             done
);

  localparam int SAT = MANT_W + 1;
  localparam int ACW = $clog2(SAT + 1);
  localparam int NCW = $clog2(MANT_W);

  typedef enum logic [2:0] {
    IDLE, LOAD, CMP, ALIGN, ADD, NORM, DONE
  } state_t;

  state_t         state;
  logic [ACW-1:0] align_cnt;
  logic [ACW-1:0] align_init;
  logic [NCW-1:0] norm_cnt;
  logic           norm_active;
  logic           norm_left;

  // Beyond MANT_W+1 shifts the smaller mantissa is already all zeros.
  always_comb begin
    align_init = ACW'(exp_diff);
    if (32'(exp_diff) >= 32'(SAT)) align_init = ACW'(SAT);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      align_cnt   <= '0;
      norm_cnt    <= '0;
      swap_sel    <= 1'b0;
      ready       <= 1'b1;
      load_ops    <= 1'b0;
      load_mants  <= 1'b0;
      shift_align <= 1'b0;
      load_sum    <= 1'b0;
      done        <= 1'b0;
    end else begin
      load_ops    <= 1'b0;
      load_mants  <= 1'b0;
      shift_align <= 1'b0;
      load_sum    <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= LOAD;
          load_ops <= 1'b1;
          ready    <= 1'b0;
        end
        LOAD: begin
          state      <= CMP;
          load_mants <= 1'b1;
        end
        CMP: begin
          swap_sel  <= swap;
          align_cnt <= align_init;
          if (align_init == '0) begin
            state    <= ADD;
            load_sum <= 1'b1;
          end else begin
            state       <= ALIGN;
            shift_align <= 1'b1;
          end
        end
        ALIGN: begin
          align_cnt <= align_cnt - ACW'(1);
          if (align_cnt == ACW'(1)) begin
            state    <= ADD;
            load_sum <= 1'b1;
          end else begin
            shift_align <= 1'b1;
          end
        end
        ADD: begin
          state    <= NORM;
          norm_cnt <= '0;
        end
        NORM: begin
          if (norm_left) begin
            norm_cnt <= norm_cnt + NCW'(1);
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Normalisation strobes react to the registered-sum flags in the same cycle.
  assign norm_active  = (state == NORM);
  assign norm_left    = norm_active && !sum_zero && !carry_out && !sum_msb &&
                        (norm_cnt < NCW'(MANT_W - 1));
  assign exp_zero     = norm_active && sum_zero;
  assign shift_norm_r = norm_active && !sum_zero && carry_out;
  assign exp_inc      = shift_norm_r;
  assign shift_norm_l = norm_left;
  assign exp_dec      = norm_left;

endmodule

// File: doc/control_adunare_fp.md
Name: control_adunare_fp

Overview:
- Sequencing controller for the floating-point adder datapath: operand/exponent registers, 50-bit mantissa-pair register, alignment shifter, mantissa adder, normalisation shifter.
- Accepts one add request per start/ready handshake.
- Walks the datapath through load, exponent compare, alignment, add and normalise.
- Issues one-cycle control strobes; pulses done when the result registers hold the normalised sum.

Parameters:
- EXP_W, 8, exponent width; width of exp_diff.
- MANT_W, 25, width of one mantissa (hidden bit included); mantissa-pair register is 2*MANT_W.

Ports:
- clk  input  1  single clock, rising-edge.
- clear_n  input  1  asynchronous active-low reset.
- start  input  1  add request; sampled only in IDLE.
- ready  output  1  high only in IDLE.
- exp_diff  input  EXP_W  |Ea-Eb| from exponent comparator; sampled in CMP.
- swap  input  1  1 when Eb>Ea; sampled in CMP.
- carry_out  input  1  adder overflow bit of the registered sum.
- sum_msb  input  1  hidden-bit position of the registered sum.
- sum_zero  input  1  registered sum is all zeros.
- load_ops  output  1  load operand/exponent registers.
- load_mants  output  1  load mantissa-pair register.
- swap_sel  output  1  registered swap; steers the smaller operand to the shifter.
- shift_align  output  1  right-shift smaller mantissa by 1.
- load_sum  output  1  capture adder result.
- shift_norm_r  output  1  right-shift sum by 1.
- shift_norm_l  output  1  left-shift sum by 1.
- exp_inc  output  1  result exponent +1.
- exp_dec  output  1  result exponent -1.
- exp_zero  output  1  force result exponent/mantissa to zero.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (clear_n=0, async):
  - state=IDLE, align counter=0, norm counter=0, swap_sel=0.
  - All strobes and done=0; ready=1.
  - Asserting clear_n mid-operation aborts at once; no further strobes issued.
- State sequence: IDLE, LOAD, CMP, ALIGN, ADD, NORM, DONE. The edge that samples start in IDLE is cycle 0.
- IDLE: ready=1. start=1 -> LOAD. start is ignored in every other state; holding start high restarts only after returning to IDLE.
- LOAD (1 cycle): load_ops=1 -> CMP.
- CMP (1 cycle):
  - load_mants=1; swap_sel<=swap.
  - align counter <= min(exp_diff, MANT_W+1) (saturation: the mantissa is fully shifted out).
  - Counter 0 -> ADD; otherwise -> ALIGN.
- ALIGN: shift_align=1 every cycle; counter decrements. Leave for ADD on the cycle the counter is 1, so exactly d pulses are issued.
- ADD (1 cycle): load_sum=1 -> NORM; norm counter<=0.
- NORM: strobes are Mealy outputs of the flags, evaluated each cycle with this priority:
  1. sum_zero=1: exp_zero=1 -> DONE.
  2. carry_out=1: shift_norm_r=1, exp_inc=1 -> DONE.
  3. sum_msb=0 and norm counter<MANT_W-1: shift_norm_l=1, exp_dec=1, counter+1, stay in NORM.
  4. Otherwise (msb=1 or guard reached): no strobe -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- Latency: d = saturated alignment count, n = left-shift count. load_ops at cycle 1, load_mants cycle 2, load_sum cycle 3+d, done cycle 5+d+n.
- Strobes are mutually exclusive per cycle, except the exp_* pairs with their shift.
- swap_sel holds its value until the next CMP.
- No new request can be accepted before done has pulsed.

Test Plan:
- Reset: clear_n low 3 cycles with start=1 -> ready=1, all strobes 0. After release with start=0 -> stays IDLE.
- exp_diff=0, carry_out=0, sum_msb=1 -> load_ops at cycle 1, load_mants at 2, load_sum at 3, no norm strobe at 4, done at 5, ready again at 6.
- exp_diff=3, swap=1, carry_out=1 -> swap_sel=1 from cycle 3, shift_align at cycles 3-5, load_sum at 6, shift_norm_r+exp_inc at 7, done at 8.
- exp_diff=200 -> exactly 26 shift_align pulses (MANT_W+1), load_sum at cycle 29, done at 31.
- exp_diff=0, sum_msb=0 for 4 NORM cycles then 1 -> 4 shift_norm_l/exp_dec pulses (cycles 4-7), done at 9. Repeat with sum_zero=1 -> exp_zero at 4, no shifts, done at 5.
- start pulsed during ALIGN -> ignored. clear_n asserted mid-ALIGN -> strobes 0 immediately, ready=1. Next start completes normally with fresh counters.
